window_sequencer: RTL and testbench
===================================

# window_sequencer

Runs the per-window timing sequence for the diode controller from the timing and flag set supplied by `mode_profile`. Sits directly downstream of `mode_profile`: on `start` it latches the current profile and steps through SEND → INCREASE → PAUSE → LISTEN for `num_windows` windows. It drives the phase enables, LFD control and calibration strobes for the output stages, and reports completion.

## Interface

Parameters
- TIME_W, 16, width of phase duration inputs and the phase counter
- NWIN_W, 8, width of window count input and window index

Ports
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sequence; accepted only in IDLE
- abort  in  1  terminate the running sequence
- window_send_time  in  TIME_W  SEND duration, cycles
- window_increase_time  in  TIME_W  INCREASE duration, cycles
- window_pause_time  in  TIME_W  PAUSE duration, cycles
- window_listen_time  in  TIME_W  LISTEN duration, cycles
- num_windows  in  NWIN_W  windows per sequence
- lfd_disable_before, lfd_enable_after, calibration_mode, pause_action_required  in  1 each  profile flags
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion
- phase  out  3  0 IDLE, 1 SEND, 2 INCREASE, 3 PAUSE, 4 LISTEN, 5 LFD_ON, 6 DONE
- window_idx  out  NWIN_W  current window, 0-based
- send_en, increase_en, listen_en  out  1 each  high for the whole corresponding phase
- lfd_off  out  1  high during SEND..LISTEN when lfd_disable_before is latched
- lfd_on  out  1  one-cycle pulse in LFD_ON
- pause_strobe  out  1  one-cycle pulse on the first PAUSE cycle when pause_action_required is latched
- cal_sample  out  1  one-cycle pulse on the last LISTEN cycle when calibration_mode is latched

## Operation

- Reset: state IDLE. All outputs are 0, and window_idx is 0.
- In IDLE with start=1: all duration, count and flag inputs are latched. Later changes on the inputs are ignored until the next accepted start. start is ignored outside IDLE.
- num_windows=0: go IDLE → DONE → IDLE. No phase enables are asserted.
- Otherwise each window runs SEND(S) → INCREASE(I) → PAUSE(P) → LISTEN(L), then LFD_ON for 1 cycle if lfd_enable_after is latched.
- A duration of 0 is clamped to 1 cycle.
- After each window, window_idx increments. If the new value equals num_windows, go to DONE; otherwise go to SEND.
- DONE lasts 1 cycle: done=1, busy=1, then IDLE.
- Phase counter: a down-counter loaded with duration−1 on phase entry. The phase exits when the counter is 0.
- abort=1 in any non-IDLE state: next cycle is IDLE, all outputs are 0, and there is no done pulse. abort in IDLE has no effect.
- rst has priority over abort and start.
- A simultaneous start and abort in IDLE: start is accepted.

## Timing

- Start accepted at cycle t; SEND begins at t+1.
- Window length W = S'+I'+P'+L'+(lfd_enable_after ? 1 : 0), where X' = max(X,1).
- Window k (0-based) starts at t+1+k·W.
- done is high at cycle t+1+n·W. busy is high from t+1 through the DONE cycle inclusive.
- Outputs are registered and decoded from state, so each enable matches phase exactly on the same cycle.
- send_en/increase_en/listen_en are high for exactly S'/I'/L' cycles per window. PAUSE has no enable; it is visible via phase and pause_strobe.
- A new start is accepted on the first IDLE cycle after DONE, i.e. t+2+n·W at the earliest.
- Counter width: durations up to 2^TIME_W−1 cycles. A 16-bit width covers 350 µs = 17500 cycles at 50 MHz.

## Test plan

- S=2, I=3, P=1, L=2, n=3, all flags 0, start at t=0:
  - send_en is high for cycles 1-2, 9-10 and 17-18.
  - done is high at cycle 25; busy is high for cycles 1-25.
  - window_idx steps 0, 1, 2.
- Same timing with all four flags 1:
  - W=9; lfd_off is high for cycles 1-8.
  - lfd_on pulses at 9, 18, 27.
  - pause_strobe pulses at 6, 15, 24; cal_sample pulses at 8, 17, 26.
  - done is high at cycle 28.
- Enable-mode profile at full size (1500/17500/250/5750 cycles, n=3):
  - W=25000; done is high at cycle 75001.
  - increase_en is high for cycles 1501-19000.
- Boundary durations:
  - n=0: done is high at cycle 1 with no enables.
  - All durations 0, n=2, flags 0: W=4, done is high at cycle 9.
- Abort at cycle 5 during INCREASE of the first run above: all outputs are 0 from cycle 6 and done never pulses. A start at cycle 7 is accepted, with SEND at cycle 8.
- Interference:
  - Change the profile inputs and pulse start mid-sequence: timing is unchanged.
  - Assert rst mid-LISTEN: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : window_sequencer
// Purpose  : Per-window timing sequencer for the diode controller. On an
//            accepted start it latches the mode_profile timing/flag set and
//            runs SEND -> INCREASE -> PAUSE -> LISTEN (-> LFD_ON) for
//            num_windows windows, then pulses done for one DONE cycle.
// Ports    : clk, rst                     clock, synchronous active-high reset
//            start, abort                 sequence request / termination
//            window_*_time                phase durations in cycles (0 -> 1)
//            num_windows                  windows per sequence
//            lfd_disable_before, lfd_enable_after,
//            calibration_mode, pause_action_required   profile flags
//            busy, done, phase, window_idx             sequence status
//            send_en, increase_en, listen_en           phase enables
//            lfd_off, lfd_on                           LFD control
//            pause_strobe, cal_sample                  calibration strobes
// Revision : 1.0  initial release
// ============================================================================
module window_sequencer #(
    parameter int TIME_W = 16,
    parameter int NWIN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] window_send_time,
    input  logic [TIME_W-1:0] window_increase_time,
    input  logic [TIME_W-1:0] window_pause_time,
    input  logic [TIME_W-1:0] window_listen_time,
    input  logic [NWIN_W-1:0] num_windows,
    input  logic              lfd_disable_before,
    input  logic              lfd_enable_after,
    input  logic              calibration_mode,
    input  logic              pause_action_required,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase,
    output logic [NWIN_W-1:0] window_idx,
    output logic              send_en,
    output logic              increase_en,
    output logic              listen_en,
    output logic              lfd_off,
    output logic              lfd_on,
    output logic              pause_strobe,
    output logic              cal_sample
);

    // State codes double as the phase output encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_INCREASE = 3'd2;
    localparam logic [2:0] ST_PAUSE    = 3'd3;
    localparam logic [2:0] ST_LISTEN   = 3'd4;
    localparam logic [2:0] ST_LFD_ON   = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    logic [2:0]        r_state, w_nstate;
    logic [TIME_W-1:0] r_cnt, w_ncnt, w_cnt_dec;
    logic [TIME_W-1:0] r_send_ld, r_inc_ld, r_pause_ld, r_listen_ld;
    logic [NWIN_W-1:0] r_idx, w_nidx, w_idx_inc, r_num;
    logic              r_lfd_dis, r_lfd_en, r_cal, r_pause_act;
    logic              w_accept, w_cnt_zero, w_lfd_dis;

    // Counter load value: duration-1, with a zero duration behaving as one cycle.
    function automatic logic [TIME_W-1:0] f_load(input logic [TIME_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - 1'b1;
    assign w_idx_inc  = r_idx + 1'b1;
    // On the accepting cycle the flag register is not yet loaded, so the
    // SEND entry uses the live input.
    assign w_lfd_dis  = w_accept ? lfd_disable_before : r_lfd_dis;

    assign phase      = r_state;
    assign window_idx = r_idx;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nidx   = r_idx;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nidx = '0;
                w_ncnt = '0;
                if (start) begin
                    w_accept = 1'b1;
                    if (num_windows == '0) begin
                        w_nstate = ST_DONE;
                    end else begin
                        w_nstate = ST_SEND;
                        w_ncnt   = f_load(window_send_time);
                    end
                end
            end
            ST_SEND: begin
                if (w_cnt_zero) begin
                    w_nstate = ST_INCREASE;
                    w_ncnt   = r_inc_ld;
                end else begin
                    w_ncnt = w_cnt_dec;
                end
            end
            ST_INCREASE: begin
                if (w_cnt_zero) begin
                    w_nstate = ST_PAUSE;
                    w_ncnt   = r_pause_ld;
                end else begin
                    w_ncnt = w_cnt_dec;
                end
            end
            ST_PAUSE: begin
                if (w_cnt_zero) begin
                    w_nstate = ST_LISTEN;
                    w_ncnt   = r_listen_ld;
                end else begin
                    w_ncnt = w_cnt_dec;
                end
            end
            ST_LISTEN: begin
                if (!w_cnt_zero) begin
                    w_ncnt = w_cnt_dec;
                end else if (r_lfd_en) begin
                    w_nstate = ST_LFD_ON;
                    w_ncnt   = '0;
                end else begin
                    w_nidx   = w_idx_inc;
                    w_nstate = (w_idx_inc == r_num) ? ST_DONE : ST_SEND;
                    w_ncnt   = r_send_ld;
                end
            end
            ST_LFD_ON: begin
                w_nidx   = w_idx_inc;
                w_nstate = (w_idx_inc == r_num) ? ST_DONE : ST_SEND;
                w_ncnt   = r_send_ld;
            end
            ST_DONE: begin
                w_nstate = ST_IDLE;
                w_nidx   = '0;
                w_ncnt   = '0;
            end
            default: begin
                w_nstate = ST_IDLE;
                w_nidx   = '0;
                w_ncnt   = '0;
            end
        endcase
        // Abort overrides everything except an idle-state start.
        if (abort && (r_state != ST_IDLE)) begin
            w_nstate = ST_IDLE;
            w_nidx   = '0;
            w_ncnt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_num        <= '0;
            r_send_ld    <= '0;
            r_inc_ld     <= '0;
            r_pause_ld   <= '0;
            r_listen_ld  <= '0;
            r_lfd_dis    <= 1'b0;
            r_lfd_en     <= 1'b0;
            r_cal        <= 1'b0;
            r_pause_act  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            send_en      <= 1'b0;
            increase_en  <= 1'b0;
            listen_en    <= 1'b0;
            lfd_off      <= 1'b0;
            lfd_on       <= 1'b0;
            pause_strobe <= 1'b0;
            cal_sample   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_idx   <= w_nidx;
            if (w_accept) begin
                r_num       <= num_windows;
                r_send_ld   <= f_load(window_send_time);
                r_inc_ld    <= f_load(window_increase_time);
                r_pause_ld  <= f_load(window_pause_time);
                r_listen_ld <= f_load(window_listen_time);
                r_lfd_dis   <= lfd_disable_before;
                r_lfd_en    <= lfd_enable_after;
                r_cal       <= calibration_mode;
                r_pause_act <= pause_action_required;
            end
            // Outputs are decoded from the next state so they line up with phase.
            busy         <= (w_nstate != ST_IDLE);
            done         <= (w_nstate == ST_DONE);
            send_en      <= (w_nstate == ST_SEND);
            increase_en  <= (w_nstate == ST_INCREASE);
            listen_en    <= (w_nstate == ST_LISTEN);
            lfd_off      <= w_lfd_dis && (w_nstate >= ST_SEND) && (w_nstate <= ST_LISTEN);
            lfd_on       <= (w_nstate == ST_LFD_ON);
            pause_strobe <= r_pause_act && (w_nstate == ST_PAUSE) && (r_state != ST_PAUSE);
            cal_sample   <= r_cal && (w_nstate == ST_LISTEN) && (w_ncnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_sequencer
// Purpose  : Self-checking bench for window_sequencer. A cycle-indexed model
//            derives every output from the window arithmetic (offset / W,
//            offset % W) and is compared on every cycle; directed literal
//            checks pin the documented cycle numbers.
// Revision : 1.0  initial release
// ============================================================================
module tb_window_sequencer;

    localparam int TIME_W = 16;
    localparam int NWIN_W = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [TIME_W-1:0] window_send_time;
    logic [TIME_W-1:0] window_increase_time;
    logic [TIME_W-1:0] window_pause_time;
    logic [TIME_W-1:0] window_listen_time;
    logic [NWIN_W-1:0] num_windows;
    logic              lfd_disable_before;
    logic              lfd_enable_after;
    logic              calibration_mode;
    logic              pause_action_required;
    logic              busy;
    logic              done;
    logic [2:0]        phase;
    logic [NWIN_W-1:0] window_idx;
    logic              send_en;
    logic              increase_en;
    logic              listen_en;
    logic              lfd_off;
    logic              lfd_on;
    logic              pause_strobe;
    logic              cal_sample;

    window_sequencer #(.TIME_W(TIME_W), .NWIN_W(NWIN_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .abort                 (abort),
        .window_send_time      (window_send_time),
        .window_increase_time  (window_increase_time),
        .window_pause_time     (window_pause_time),
        .window_listen_time    (window_listen_time),
        .num_windows           (num_windows),
        .lfd_disable_before    (lfd_disable_before),
        .lfd_enable_after      (lfd_enable_after),
        .calibration_mode      (calibration_mode),
        .pause_action_required (pause_action_required),
        .busy                  (busy),
        .done                  (done),
        .phase                 (phase),
        .window_idx            (window_idx),
        .send_en               (send_en),
        .increase_en           (increase_en),
        .listen_en             (listen_en),
        .lfd_off               (lfd_off),
        .lfd_on                (lfd_on),
        .pause_strobe          (pause_strobe),
        .cal_sample            (cal_sample)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Cycle k spans posedge k .. posedge k+1; outputs are sampled at its negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    // Model of the run currently in flight (profile as latched at start).
    bit m_valid = 1'b0;
    int m_t, m_s, m_i, m_p, m_l, m_n, m_kill;
    bit m_dis, m_en, m_cal, m_pa;

    // Expected output vector for cycle c:
    // {busy, done, phase, window_idx, send_en, increase_en, listen_en,
    //  lfd_off, lfd_on, pause_strobe, cal_sample}
    function automatic logic [19:0] model(input int c);
        int off, w, k, r;
        logic [2:0] ph;
        logic [7:0] idx;
        logic b, d, ps, cs;
        ph = 3'd0; idx = 8'd0; b = 1'b0; d = 1'b0; ps = 1'b0; cs = 1'b0;
        if (m_valid && c <= m_kill) begin
            off = c - m_t - 1;
            w   = m_s + m_i + m_p + m_l + (m_en ? 1 : 0);
            if (off >= 0 && off < m_n * w) begin
                k = off / w;
                r = off % w;
                b = 1'b1;
                idx = 8'(k);
                if (r < m_s)                          ph = 3'd1;
                else if (r < m_s + m_i)               ph = 3'd2;
                else if (r < m_s + m_i + m_p)         ph = 3'd3;
                else if (r < m_s + m_i + m_p + m_l)   ph = 3'd4;
                else                                  ph = 3'd5;
                ps = m_pa  && (r == m_s + m_i);
                cs = m_cal && (r == m_s + m_i + m_p + m_l - 1);
            end else if (off >= 0 && off == m_n * w) begin
                b = 1'b1; d = 1'b1; ph = 3'd6; idx = 8'(m_n);
            end
        end
        return {b, d, ph, idx, ph == 3'd1, ph == 3'd2, ph == 3'd4,
                m_dis && ph >= 3'd1 && ph <= 3'd4, ph == 3'd5, ps, cs};
    endfunction

    always @(negedge clk) begin
        logic [19:0] exp_v, act_v;
        if (chk_on) begin
            exp_v = model(cyc);
            act_v = {busy, done, phase, window_idx, send_en, increase_en, listen_en,
                     lfd_off, lfd_on, pause_strobe, cal_sample};
            n_checks++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_model cyc=%0d got=%h expected=%h", cyc, act_v, exp_v);
            end
        end
    end

    always @(posedge clk) begin
        if (cyc > 90000) begin
            $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_profile(input int s, input int i, input int p, input int l, input int n,
                               input bit fd, input bit fe, input bit fc, input bit fp);
        window_send_time      = 16'(s);
        window_increase_time  = 16'(i);
        window_pause_time     = 16'(p);
        window_listen_time    = 16'(l);
        num_windows           = 8'(n);
        lfd_disable_before    = fd;
        lfd_enable_after      = fe;
        calibration_mode      = fc;
        pause_action_required = fp;
    endtask

    // Starts a run on the current cycle and records it in the model.
    task automatic run(input int s, input int i, input int p, input int l, input int n,
                       input bit fd, input bit fe, input bit fc, input bit fp);
        set_profile(s, i, p, l, n, fd, fe, fc, fp);
        start  = 1'b1;
        m_t    = cyc;
        m_s    = (s == 0) ? 1 : s;
        m_i    = (i == 0) ? 1 : i;
        m_p    = (p == 0) ? 1 : p;
        m_l    = (l == 0) ? 1 : l;
        m_n    = n;
        m_dis  = fd; m_en = fe; m_cal = fc; m_pa = fp;
        m_kill = 32'h7fffffff;
        m_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_profile(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_phase", int'(phase), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_idx", int'(window_idx), 0);
        chk_on = 1'b1;
        @(negedge clk);

        // Basic timing, no flags: W = 8
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 1);  chk("a_send_1", int'(send_en), 1);
        at(t + 2);  chk("a_send_2", int'(send_en), 1);
        at(t + 3);  chk("a_send_3", int'(send_en), 0);
        at(t + 9);  chk("a_send_9", int'(send_en), 1);
        at(t + 17); chk("a_idx_17", int'(window_idx), 2);
        at(t + 24); chk("a_done_24", int'(done), 0);
        at(t + 25); chk("a_done_25", int'(done), 1);
                    chk("a_busy_25", int'(busy), 1);
        at(t + 26); chk("a_busy_26", int'(busy), 0);

        // Back-to-back start, all flags: W = 9
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b1, 1'b1, 1'b1, 1'b1);
        at(t + 6);  chk("b_pause_6", int'(pause_strobe), 1);
        at(t + 8);  chk("b_cal_8", int'(cal_sample), 1);
                    chk("b_lfdoff_8", int'(lfd_off), 1);
        at(t + 9);  chk("b_lfdon_9", int'(lfd_on), 1);
                    chk("b_lfdoff_9", int'(lfd_off), 0);
        at(t + 18); chk("b_lfdon_18", int'(lfd_on), 1);
        at(t + 27); chk("b_lfdon_27", int'(lfd_on), 1);
        at(t + 28); chk("b_done_28", int'(done), 1);
        at(t + 29);

        // Zero windows
        t = cyc;
        run(2, 3, 1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        at(t + 1);  chk("c_done_1", int'(done), 1);
                    chk("c_send_1", int'(send_en), 0);
        at(t + 2);  chk("c_busy_2", int'(busy), 0);
        at(t + 3);

        // All durations zero: W = 4
        t = cyc;
        run(0, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 1);  chk("d_send_1", int'(send_en), 1);
        at(t + 2);  chk("d_inc_2", int'(increase_en), 1);
        at(t + 5);  chk("d_idx_5", int'(window_idx), 1);
        at(t + 9);  chk("d_done_9", int'(done), 1);
        at(t + 12);

        // Abort during INCREASE, then restart two cycles later
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 5);  chk("e_inc_5", int'(increase_en), 1);
        abort  = 1'b1;
        m_kill = t + 5;
        at(t + 6);  abort = 1'b0;
                    chk("e_phase_6", int'(phase), 0);
                    chk("e_busy_6", int'(busy), 0);
        at(t + 7);
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 1);  chk("e_send_8", int'(send_en), 1);
        at(t + 25); chk("e_done_25", int'(done), 1);
        at(t + 27);

        // Profile change plus start pulse mid-sequence must not disturb timing
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 10);
        set_profile(7, 0, 9, 4, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        start = 1'b1;
        at(t + 11); start = 1'b0;
        at(t + 17); chk("f_send_17", int'(send_en), 1);
        at(t + 25); chk("f_done_25", int'(done), 1);
        at(t + 27);

        // Reset in the middle of LISTEN
        t = cyc;
        run(2, 3, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        at(t + 7);  chk("g_listen_7", int'(listen_en), 1);
        rst    = 1'b1;
        m_kill = t + 7;
        at(t + 8);  rst = 1'b0;
                    chk("g_phase_8", int'(phase), 0);
                    chk("g_lfdoff_8", int'(lfd_off), 0);
        at(t + 10);

        // Full-size enable-mode profile: W = 25000
        t = cyc;
        run(1500, 17500, 250, 5750, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        at(t + 1500);  chk("h_inc_1500", int'(increase_en), 0);
        at(t + 1501);  chk("h_inc_1501", int'(increase_en), 1);
        at(t + 19000); chk("h_inc_19000", int'(increase_en), 1);
        at(t + 19001); chk("h_inc_19001", int'(increase_en), 0);
        at(t + 75000); chk("h_done_75000", int'(done), 0);
        at(t + 75001); chk("h_done_75001", int'(done), 1);
        at(t + 75003);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
